multicycle_ctrl_fsm: RTL and testbench

MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

---
 rtl/multicycle_ctrl_fsm.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main control unit for a multicycle MIPS-style datapath.
// Moore state machine with registered control outputs and a retired-instruction counter.
module multicycle_ctrl_fsm #(
   parameter bit EXT_ISA       = 1'b1,
   parameter bit USE_MEM_READY = 1'b1,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             Branch,
   output logic             BranchNe,
   output logic             ALUSrcA,
   output logic             RegWrite,
   output logic             ImmZeroExt,
   output logic [1:0]       PCSrc,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       RegDst,
   output logic [1:0]       MemtoReg,
   output logic [2:0]       ALUOp,
   output logic [3:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_REX    = 4'd6,
      S_RWB    = 4'd7,
      S_BEQ    = 4'd8,
      S_IMMEX  = 4'd9,
      S_IMMWB  = 4'd10,
      S_J      = 4'd11,
      S_BNE    = 4'd12,
      S_JAL    = 4'd13,
      S_ILL    = 4'd15
   } state_e;

   typedef struct packed {
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       fetch;       // IRWrite/PCWrite follow ready in this state
      logic       pc_write;
      logic       branch;
      logic       branch_ne;
      logic       alu_src_a;
      logic       reg_write;
      logic       imm_zero_ext;
      logic [1:0] pc_src;
      logic [1:0] alu_src_b;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic [2:0] alu_op;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;

   // Control word for a state. op only matters for IMMEX, which is entered from DECODE.
   function automatic ctrl_t decode(input state_e s, input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.fetch     = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE: c.alu_src_b = 2'b11;
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            c.iord     = 1'b1;
            c.mem_read = 1'b1;
         end
         S_MEMWB: begin
            c.mem_to_reg = 2'b01;
            c.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         S_REX: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_FUNCT;
         end
         S_RWB: begin
            c.reg_dst   = 2'b01;
            c.reg_write = 1'b1;
         end
         S_BEQ, S_BNE: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_SUB;
            c.pc_src    = 2'b01;
            c.branch    = (s == S_BEQ);
            c.branch_ne = (s == S_BNE);
         end
         S_IMMEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            case (op)
               OP_ANDI: begin
                  c.alu_op       = ALU_AND;
                  c.imm_zero_ext = 1'b1;
               end
               OP_ORI: begin
                  c.alu_op       = ALU_OR;
                  c.imm_zero_ext = 1'b1;
               end
               default: c.alu_op = ALU_ADD;
            endcase
         end
         S_IMMWB: c.reg_write = 1'b1;
         S_J: begin
            c.pc_src   = 2'b10;
            c.pc_write = 1'b1;
         end
         S_JAL: begin
            c.pc_src     = 2'b10;
            c.pc_write   = 1'b1;
            c.reg_write  = 1'b1;
            c.reg_dst    = 2'b10;
            c.mem_to_reg = 2'b10;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_e           state_q, state_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             ready;
   logic             retire;

   assign ready = USE_MEM_READY ? mem_ready : 1'b1;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:              state_d = S_MEMADR;
               OP_RTYPE:                  state_d = S_REX;
               OP_BEQ:                    state_d = S_BEQ;
               OP_J:                      state_d = S_J;
               OP_BNE:                    state_d = EXT_ISA ? S_BNE : S_ILL;
               OP_ADDI, OP_ANDI, OP_ORI:  state_d = EXT_ISA ? S_IMMEX : S_ILL;
               OP_JAL:                    state_d = EXT_ISA ? S_JAL : S_ILL;
               default:                   state_d = S_ILL;
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = ready ? S_MEMWB : S_MEMRD;
         S_MEMWR: begin
            state_d = ready ? S_FETCH : S_MEMWR;
            retire  = ready;
         end
         S_REX:    state_d = S_RWB;
         S_IMMEX:  state_d = S_IMMWB;
         S_MEMWB, S_RWB, S_BEQ, S_BNE, S_IMMWB, S_J, S_JAL: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_ILL:    state_d = S_ILL;
         default:  state_d = S_FETCH;
      endcase

      // Outputs are registered from the next state, so they match a decode of state_q.
      ctrl_d    = decode(state_d, opcode);
      illegal_d = illegal_q | (state_d == S_ILL);
      retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         ctrl_q    <= decode(S_FETCH, 6'b000000);
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   assign IorD       = ctrl_q.iord;
   assign MemRead    = ctrl_q.mem_read;
   assign MemWrite   = ctrl_q.mem_write;
   assign IRWrite    = ctrl_q.fetch & ready & ~reset;
   assign PCWrite    = (ctrl_q.fetch & ready & ~reset) | ctrl_q.pc_write;
   assign Branch     = ctrl_q.branch;
   assign BranchNe   = ctrl_q.branch_ne;
   assign ALUSrcA    = ctrl_q.alu_src_a;
   assign RegWrite   = ctrl_q.reg_write;
   assign ImmZeroExt = ctrl_q.imm_zero_ext;
   assign PCSrc      = ctrl_q.pc_src;
   assign ALUSrcB    = ctrl_q.alu_src_b;
   assign RegDst     = ctrl_q.reg_dst;
   assign MemtoReg   = ctrl_q.mem_to_reg;
   assign ALUOp      = ctrl_q.alu_op;
   assign state      = state_q;
   assign illegal    = illegal_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: default, base-ISA and 4-bit-counter instances
// share clock and inputs; each scenario resets all three and checks the instance of interest.
module tb_multicycle_ctrl_fsm;

   logic       clk;
   logic       reset;
   logic       mem_ready;
   logic [5:0] opcode;

   logic       d_IorD, d_MemRead, d_MemWrite, d_IRWrite, d_PCWrite, d_Branch, d_BranchNe;
   logic       d_ALUSrcA, d_RegWrite, d_ImmZeroExt, d_illegal;
   logic [1:0] d_PCSrc, d_ALUSrcB, d_RegDst, d_MemtoReg;
   logic [2:0] d_ALUOp;
   logic [3:0] d_state;
   logic [31:0] d_retired;

   logic       b_IorD, b_MemRead, b_MemWrite, b_IRWrite, b_PCWrite, b_Branch, b_BranchNe;
   logic       b_ALUSrcA, b_RegWrite, b_ImmZeroExt, b_illegal;
   logic [1:0] b_PCSrc, b_ALUSrcB, b_RegDst, b_MemtoReg;
   logic [2:0] b_ALUOp;
   logic [3:0] b_state;
   logic [31:0] b_retired;

   logic       w_IorD, w_MemRead, w_MemWrite, w_IRWrite, w_PCWrite, w_Branch, w_BranchNe;
   logic       w_ALUSrcA, w_RegWrite, w_ImmZeroExt, w_illegal;
   logic [1:0] w_PCSrc, w_ALUSrcB, w_RegDst, w_MemtoReg;
   logic [2:0] w_ALUOp;
   logic [3:0] w_state;
   logic [3:0] w_retired;

   int n_checks = 0;
   int n_errors = 0;

   multicycle_ctrl_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .IorD(d_IorD), .MemRead(d_MemRead), .MemWrite(d_MemWrite), .IRWrite(d_IRWrite),
      .PCWrite(d_PCWrite), .Branch(d_Branch), .BranchNe(d_BranchNe), .ALUSrcA(d_ALUSrcA),
      .RegWrite(d_RegWrite), .ImmZeroExt(d_ImmZeroExt), .PCSrc(d_PCSrc), .ALUSrcB(d_ALUSrcB),
      .RegDst(d_RegDst), .MemtoReg(d_MemtoReg), .ALUOp(d_ALUOp), .state(d_state),
      .illegal(d_illegal), .retired(d_retired)
   );

   multicycle_ctrl_fsm #(.EXT_ISA(1'b0)) dut_base (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .IorD(b_IorD), .MemRead(b_MemRead), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite),
      .PCWrite(b_PCWrite), .Branch(b_Branch), .BranchNe(b_BranchNe), .ALUSrcA(b_ALUSrcA),
      .RegWrite(b_RegWrite), .ImmZeroExt(b_ImmZeroExt), .PCSrc(b_PCSrc), .ALUSrcB(b_ALUSrcB),
      .RegDst(b_RegDst), .MemtoReg(b_MemtoReg), .ALUOp(b_ALUOp), .state(b_state),
      .illegal(b_illegal), .retired(b_retired)
   );

   multicycle_ctrl_fsm #(.CNT_W(4)) dut_w4 (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .IorD(w_IorD), .MemRead(w_MemRead), .MemWrite(w_MemWrite), .IRWrite(w_IRWrite),
      .PCWrite(w_PCWrite), .Branch(w_Branch), .BranchNe(w_BranchNe), .ALUSrcA(w_ALUSrcA),
      .RegWrite(w_RegWrite), .ImmZeroExt(w_ImmZeroExt), .PCSrc(w_PCSrc), .ALUSrcB(w_ALUSrcB),
      .RegDst(w_RegDst), .MemtoReg(w_MemtoReg), .ALUOp(w_ALUOp), .state(w_state),
      .illegal(w_illegal), .retired(w_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of run, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From FETCH, run through FETCH and DECODE with ready high; ends in the first execute state.
   task automatic prelude(input logic [5:0] op);
      opcode    = op;
      mem_ready = 1'b1;
      tick();
      tick();
   endtask

   int exp_ret;
   int mw_cycles;
   logic [3:0] lw_states [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

   initial begin
      reset     = 1'b1;
      opcode    = 6'b000000;
      mem_ready = 1'b1;
      exp_ret   = 0;
      #1;
      // Reset state: FETCH decodes but no IR/PC write even with ready high
      check("rst_state",   32'(d_state),   32'd0);
      check("rst_retired", d_retired,      32'd0);
      check("rst_illegal", 32'(d_illegal), 32'd0);
      check("rst_irwrite", 32'(d_IRWrite), 32'd0);
      check("rst_pcwrite", 32'(d_PCWrite), 32'd0);
      check("rst_memread", 32'(d_MemRead), 32'd1);
      check("rst_alusrcb", 32'(d_ALUSrcB), 32'd1);
      tick();
      tick();
      reset = 1'b0;

      // lw with zero wait states: 0,1,2,3,4,0
      opcode = 6'b100011;
      #1;
      check("lw_fetch_state", 32'(d_state),   32'd0);
      check("lw_fetch_ir",    32'(d_IRWrite), 32'd1);
      check("lw_fetch_rw",    32'(d_RegWrite), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("lw_state_%0d", i), 32'(d_state), 32'(lw_states[i]));
         check($sformatf("lw_regwrite_%0d", i), 32'(d_RegWrite), (lw_states[i] == 4'd4) ? 32'd1 : 32'd0);
         if (lw_states[i] == 4'd3) check("lw_memrd_iord", 32'(d_IorD), 32'd1);
         if (lw_states[i] == 4'd4) check("lw_memwb_mtr", 32'(d_MemtoReg), 32'd1);
      end
      exp_ret++;
      check("lw_retired", d_retired, 32'(exp_ret));

      // sw with three wait cycles in MEMWR
      prelude(6'b101011);
      tick();
      mw_cycles = 0;
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k == 3);
         #1;
         check($sformatf("sw_wait_state_%0d", k), 32'(d_state), 32'd5);
         check($sformatf("sw_wait_ret_%0d", k), d_retired, 32'(exp_ret));
         if (d_MemWrite) mw_cycles++;
         tick();
      end
      exp_ret++;
      check("sw_memwrite_cycles", 32'(mw_cycles), 32'd4);
      check("sw_done_state",      32'(d_state),   32'd0);
      check("sw_retired",         d_retired,      32'(exp_ret));

      // FETCH stalled two cycles, then a j
      opcode    = 6'b000010;
      mem_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         check($sformatf("stall_state_%0d", k), 32'(d_state),   32'd0);
         check($sformatf("stall_ir_%0d", k),    32'(d_IRWrite), 32'd0);
         check($sformatf("stall_pc_%0d", k),    32'(d_PCWrite), 32'd0);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      check("stall_go_ir", 32'(d_IRWrite), 32'd1);
      check("stall_go_pc", 32'(d_PCWrite), 32'd1);
      tick();
      check("j_decode_state", 32'(d_state),   32'd1);
      check("j_decode_ir",    32'(d_IRWrite), 32'd0);
      tick();
      check("j_state",   32'(d_state),   32'd11);
      check("j_pcwrite", 32'(d_PCWrite), 32'd1);
      check("j_pcsrc",   32'(d_PCSrc),   32'd2);
      tick();
      exp_ret++;
      check("j_retired", d_retired, 32'(exp_ret));

      // R-type
      prelude(6'b000000);
      check("r_state", 32'(d_state), 32'd6);
      check("r_aluop", 32'(d_ALUOp), 32'd2);
      check("r_srca",  32'(d_ALUSrcA), 32'd1);
      check("r_srcb",  32'(d_ALUSrcB), 32'd0);
      tick();
      check("rwb_state",  32'(d_state),    32'd7);
      check("rwb_regdst", 32'(d_RegDst),   32'd1);
      check("rwb_rw",     32'(d_RegWrite), 32'd1);
      tick();
      exp_ret++;

      // beq and bne
      prelude(6'b000100);
      check("beq_state",  32'(d_state),    32'd8);
      check("beq_branch", 32'(d_Branch),   32'd1);
      check("beq_bne",    32'(d_BranchNe), 32'd0);
      check("beq_aluop",  32'(d_ALUOp),    32'd1);
      check("beq_pcsrc",  32'(d_PCSrc),    32'd1);
      tick();
      exp_ret++;
      prelude(6'b000101);
      check("bne_state",  32'(d_state),    32'd12);
      check("bne_bne",    32'(d_BranchNe), 32'd1);
      check("bne_branch", 32'(d_Branch),   32'd0);
      tick();
      exp_ret++;

      // addi, andi, ori
      prelude(6'b001000);
      check("addi_state", 32'(d_state),      32'd9);
      check("addi_aluop", 32'(d_ALUOp),      32'd0);
      check("addi_zext",  32'(d_ImmZeroExt), 32'd0);
      check("addi_srcb",  32'(d_ALUSrcB),    32'd2);
      tick();
      check("immwb_state", 32'(d_state),    32'd10);
      check("immwb_rw",    32'(d_RegWrite), 32'd1);
      check("immwb_mtr",   32'(d_MemtoReg), 32'd0);
      tick();
      exp_ret++;
      prelude(6'b001100);
      check("andi_aluop", 32'(d_ALUOp),      32'd3);
      check("andi_zext",  32'(d_ImmZeroExt), 32'd1);
      tick();
      tick();
      exp_ret++;
      prelude(6'b001101);
      check("ori_state", 32'(d_state),      32'd9);
      check("ori_aluop", 32'(d_ALUOp),      32'd4);
      check("ori_zext",  32'(d_ImmZeroExt), 32'd1);
      opcode = 6'b111111;
      #1;
      check("ori_opcode_ignored", 32'(d_ALUOp), 32'd4);
      tick();
      tick();
      exp_ret++;

      // jal
      prelude(6'b000011);
      check("jal_state",  32'(d_state),    32'd13);
      check("jal_pcw",    32'(d_PCWrite),  32'd1);
      check("jal_pcsrc",  32'(d_PCSrc),    32'd2);
      check("jal_rw",     32'(d_RegWrite), 32'd1);
      check("jal_regdst", 32'(d_RegDst),   32'd2);
      check("jal_mtr",    32'(d_MemtoReg), 32'd2);
      tick();
      exp_ret++;
      check("ext_retired", d_retired, 32'(exp_ret));

      // Base ISA: jal is illegal and sticks until reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      prelude(6'b000011);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("ill_state_%0d", k),   32'(b_state),   32'd15);
         check($sformatf("ill_flag_%0d", k),    32'(b_illegal), 32'd1);
         check($sformatf("ill_memread_%0d", k), 32'(b_MemRead), 32'd0);
         tick();
      end
      check("ill_retired", b_retired, 32'd0);
      reset = 1'b1;
      #1;
      check("ill_rst_state", 32'(b_state),   32'd0);
      check("ill_rst_flag",  32'(b_illegal), 32'd0);

      // 17 back-to-back j: 4-bit counter wraps to 1
      tick();
      reset = 1'b0;
      for (int n = 0; n < 17; n++) begin
         prelude(6'b000010);
         tick();
      end
      check("w4_state",   32'(w_state),   32'd0);
      check("w4_wrap",    32'(w_retired), 32'd1);
      check("d_ret_17",   d_retired,      32'd17);

      // Reset in MEMRD abandons the lw immediately
      prelude(6'b100011);
      tick();
      check("abort_memrd_state", 32'(d_state),   32'd3);
      check("abort_memrd_ret",   d_retired,      32'd17);
      reset = 1'b1;
      #1;
      check("abort_state",   32'(d_state),   32'd0);
      check("abort_retired", d_retired,      32'd0);
      check("abort_ir",      32'(d_IRWrite), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("after_abort_state", 32'(d_state), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
